// File: rtl/imem_arbiter.sv
// Two-requester (fetch/debug) arbiter for a shared combinational imem read port.
// Define IMEM_ARB_RR_EN for round-robin arbitration; default is fixed F-priority with a D starvation guard.
module imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_valid_i,
  output logic              f_req_ready_o,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_rsp_valid_o,
  input  logic              f_rsp_ready_i,
  output logic [DATA_W-1:0] f_rsp_data_o,
  output logic              f_rsp_err_o,
  input  logic              flush_i,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic              d_rsp_valid_o,
  input  logic              d_rsp_ready_i,
  output logic [DATA_W-1:0] d_rsp_data_o,
  output logic              d_rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_inst_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RSP_F, RSP_D} state_t;

  state_t            state;
  logic [DATA_W-1:0] f_data_q, d_data_q;
  logic              f_err_q, d_err_q;
  logic [ADDR_W-1:0] addr_q;

  logic              f_hs, d_hs, open, pick_d, f_win, d_win, acc, acc_err;
  logic [ADDR_W-1:0] acc_addr;

`ifdef IMEM_ARB_RR_EN
  logic last_d;
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt;
`endif

  always_comb begin
    f_hs = (state == RSP_F) && f_rsp_ready_i;
    d_hs = (state == RSP_D) && d_rsp_ready_i;
    // Gating with rst_ni keeps both readies low while reset is asserted
    open = rst_ni && ((state == IDLE) || f_hs || d_hs || ((state == RSP_F) && flush_i));
`ifdef IMEM_ARB_RR_EN
    pick_d = !last_d;
`else
    pick_d = (starve_cnt == STARVE_LIM);
`endif
    f_win    = open && f_req_valid_i && (!d_req_valid_i || !pick_d);
    d_win    = open && d_req_valid_i && (!f_req_valid_i || pick_d);
    acc      = f_win || d_win;
    acc_addr = f_win ? f_addr_i : d_addr_i;
    acc_err  = (|acc_addr[1:0]) || ((acc_addr >> 2) >= ADDR_W'(IMEM_DEPTH));
  end

  assign f_req_ready_o = f_win;
  assign d_req_ready_o = d_win;
  assign mem_addr_o    = acc ? acc_addr : addr_q;
  assign f_rsp_valid_o = (state == RSP_F);
  assign d_rsp_valid_o = (state == RSP_D);
  assign f_rsp_data_o  = f_data_q;
  assign f_rsp_err_o   = f_err_q;
  assign d_rsp_data_o  = d_data_q;
  assign d_rsp_err_o   = d_err_q;
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      f_data_q <= '0;
      d_data_q <= '0;
      f_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      addr_q   <= '0;
    end else if (acc) begin
      addr_q <= acc_addr;
      if (f_win) begin
        state    <= RSP_F;
        f_data_q <= acc_err ? '0 : mem_inst_i;
        f_err_q  <= acc_err;
      end else begin
        state    <= RSP_D;
        d_data_q <= acc_err ? '0 : mem_inst_i;
        d_err_q  <= acc_err;
      end
    end else if (open) begin
      // Handshake or flush with nothing new to take on
      state <= IDLE;
    end
  end

`ifdef IMEM_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  last_d <= 1'b0;
    else if (acc) last_d <= d_win;
  end
`else
  // Counts only arbitrations D actually loses; a closed window holds the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             starve_cnt <= '0;
    else if (!d_req_valid_i || d_win)        starve_cnt <= '0;
    else if (open && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed steps then randomized traffic vs a transaction-level model.
module tb_imem_arbiter;
  localparam int DEPTH = 1024;
  localparam int SMAX  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req_valid = 0, f_rsp_ready = 0, flush = 0;
  logic        d_req_valid = 0, d_rsp_ready = 0;
  logic [31:0] f_addr = 0, d_addr = 0;
  logic        f_req_ready, f_rsp_valid, f_rsp_err;
  logic        d_req_ready, d_rsp_valid, d_rsp_err, busy;
  logic [31:0] f_rsp_data, d_rsp_data, mem_addr, mem_inst;

  logic [31:0] imem [DEPTH];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_valid_i(f_req_valid), .f_req_ready_o(f_req_ready), .f_addr_i(f_addr),
    .f_rsp_valid_o(f_rsp_valid), .f_rsp_ready_i(f_rsp_ready), .f_rsp_data_o(f_rsp_data),
    .f_rsp_err_o(f_rsp_err), .flush_i(flush),
    .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_addr_i(d_addr),
    .d_rsp_valid_o(d_rsp_valid), .d_rsp_ready_i(d_rsp_ready), .d_rsp_data_o(d_rsp_data),
    .d_rsp_err_o(d_rsp_err), .mem_addr_o(mem_addr), .mem_inst_i(mem_inst), .busy_o(busy)
  );

  // Combinational imem; out-of-range reads return junk the DUT must not forward
  always_comb begin
    if ((mem_addr >> 2) < DEPTH) mem_inst = imem[mem_addr[11:2]];
    else                         mem_inst = 32'hDEAD_BEEF;
  end

  int nchk = 0, nfail = 0;

  // Reference model: who owns the outstanding response (0 none, 1 F, 2 D) and what it must carry
  int          pend = 0, last = 1, cnt = 0;
  logic [31:0] pdata = 0, lastaddr = 0;
  logic        perr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // One clock: check against the model at negedge, advance the model, return at posedge+1
  task automatic tick();
    int win;
    bit open;
    logic [31:0] a;
    @(negedge clk);
    chk("f_rsp_valid", f_rsp_valid, pend == 1);
    chk("d_rsp_valid", d_rsp_valid, pend == 2);
    chk("busy", busy, pend != 0);
    if (pend == 1) begin chk("f_rsp_data", f_rsp_data, pdata); chk("f_rsp_err", f_rsp_err, perr); end
    if (pend == 2) begin chk("d_rsp_data", d_rsp_data, pdata); chk("d_rsp_err", d_rsp_err, perr); end
    open = (pend == 0) || (pend == 1 && (f_rsp_ready || flush)) || (pend == 2 && d_rsp_ready);
    win = 0;
    if (open) begin
      if (f_req_valid && !d_req_valid) win = 1;
      else if (d_req_valid && !f_req_valid) win = 2;
      else if (f_req_valid && d_req_valid) begin
`ifdef IMEM_ARB_RR_EN
        win = (last == 1) ? 2 : 1;
`else
        win = (cnt >= SMAX) ? 2 : 1;
`endif
      end
    end
    chk("f_req_ready", f_req_ready, win == 1);
    chk("d_req_ready", d_req_ready, win == 2);
    if (d_req_valid && win != 2 && open) cnt = (cnt < SMAX) ? cnt + 1 : SMAX;
    else if (!d_req_valid || win == 2)  cnt = 0;
    if (win != 0) begin
      a = (win == 1) ? f_addr : d_addr;
      chk("mem_addr_acc", mem_addr, a);
      lastaddr = a;
      perr  = addr_bad(a);
      pdata = perr ? 32'h0 : imem[a[11:2]];
      pend  = win;
      last  = win;
    end else begin
      chk("mem_addr_hold", mem_addr, lastaddr);
      if (open) pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (r == 7) return {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    return 32'($urandom_range(DEPTH, 5000)) << 2;
  endfunction

  int exp_win;
  int got_win;

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom | 32'h1;
    imem[2] = 32'h0051_0093;

    // Reset: valids and readies low even with a request present
    f_req_valid = 1; d_req_valid = 1;
    #2;
    chk("rst_f_ready", f_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_f_valid", f_rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    f_req_valid = 0; d_req_valid = 0;
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Single fetch
    f_req_valid = 1; f_addr = 32'h8; f_rsp_ready = 0;
    #1 chk("single_f_ready", f_req_ready, 1);
    tick();
    chk("single_f_valid", f_rsp_valid, 1);
    chk("single_f_data", f_rsp_data, 32'h0051_0093);
    chk("single_f_err", f_rsp_err, 0);
    f_req_valid = 0; f_rsp_ready = 1;
    tick();

    // Misaligned then out-of-range debug reads, back to back
    d_req_valid = 1; d_addr = 32'h6; d_rsp_ready = 1;
    tick();
    chk("misalign_err", d_rsp_err, 1);
    chk("misalign_data", d_rsp_data, 0);
    d_addr = 32'h1000;
    tick();
    chk("range_err", d_rsp_err, 1);
    chk("range_data", d_rsp_data, 0);
    d_req_valid = 0;
    tick();

    // Contention with both response channels always ready
    f_req_valid = 1; d_req_valid = 1; f_rsp_ready = 1; d_rsp_ready = 1;
    for (int k = 0; k < 10; k++) begin
      f_addr = {20'h0, 10'(k), 2'b00}; d_addr = {20'h0, 10'(k + 100), 2'b00};
      #1;
`ifdef IMEM_ARB_RR_EN
      exp_win = (k % 2 == 0) ? 1 : 2;
`else
      exp_win = (k == SMAX) ? 2 : 1;
`endif
      got_win = f_req_ready ? 1 : (d_req_ready ? 2 : 0);
      chk($sformatf("contend_grant%0d", k), got_win, exp_win);
      tick();
    end
    f_req_valid = 0; d_req_valid = 0;
    tick();

    // Backpressure on the fetch response
    f_req_valid = 1; f_addr = 32'h10; f_rsp_ready = 0;
    tick();
    f_addr = 32'h14; d_req_valid = 1; d_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_f_ready", f_req_ready, 0);
      chk("stall_d_ready", d_req_ready, 0);
      chk("stall_data", f_rsp_data, imem[4]);
      chk("stall_err", f_rsp_err, 0);
      tick();
    end
    f_rsp_ready = 1;
    #1 chk("stall_release_accept", f_req_ready | d_req_ready, 1);
    tick();
    f_req_valid = 0; d_req_valid = 0;
    tick(); tick();

    // Flush with a redirect fetch, then a bare flush
    f_req_valid = 1; f_addr = 32'h30; f_rsp_ready = 0;
    tick();
    flush = 1; f_addr = 32'h40;
    #1 chk("flush_f_ready", f_req_ready, 1);
    tick();
    flush = 0; f_req_valid = 0;
    chk("flush_new_valid", f_rsp_valid, 1);
    chk("flush_new_data", f_rsp_data, imem[16]);
    flush = 1;
    tick();
    chk("flush_kill", f_rsp_valid, 0);
    flush = 0;
    tick();

    // Asynchronous reset while a debug response is held
    d_req_valid = 1; d_addr = 32'h44; d_rsp_ready = 0;
    tick();
    chk("pre_rst_d_valid", d_rsp_valid, 1);
    d_req_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_d_valid", d_rsp_valid, 0);
    chk("async_rst_busy", busy, 0);
    pend = 0; cnt = 0; last = 1; lastaddr = 0;
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    d_rsp_ready = 1;
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      f_req_valid = ($urandom_range(0, 3) != 0);
      d_req_valid = ($urandom_range(0, 2) != 0);
      f_addr      = rnd_addr();
      d_addr      = rnd_addr();
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
